// File: rtl/cal_acc_burst.sv
// Burst copy accelerator: reads BURST words from SRC into a local buffer, writes them to DST, repeated LEN times.
// Optional build macro CAL_ACC_INV_EN enables bitwise inversion of written data when CTRL.MODE=1.
module cal_acc_burst #(
   parameter int                ADDR_W = 16,
   parameter int                DATA_W = 8,
   parameter int                BURST  = 8,
   parameter logic [ADDR_W-1:0] BASE   = 16'h0100
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] acc_data_in,
   input  logic [ADDR_W-1:0] acc_addr_in,
   input  logic              acc_write_in,
   input  logic              arb_res,
   output logic [DATA_W-1:0] acc_data_out,
   output logic [ADDR_W-1:0] acc_addr_out,
   output logic              acc_write_out,
   output logic              acc_req,
   output logic              acc_int
);

   localparam int                IW       = (BURST > 1) ? $clog2(BURST) : 1;
   localparam int                HW       = ADDR_W - DATA_W;
   localparam logic [IW-1:0]     LAST_IDX = IW'(BURST - 1);
   localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(BURST);

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      RD_A,
      RD_D,
      WR,
      NEXT,
      DONE
   } state_t;

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   ctrl_q, ctrl_d;
   logic [ADDR_W-1:0]   src_q, src_d;
   logic [ADDR_W-1:0]   dst_q, dst_d;
   logic [DATA_W-1:0]   len_q, len_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic                wrPhase_q, wrPhase_d;
   logic                int_q, int_d;
   logic [DATA_W-1:0]   buf_q [BURST];
   logic                bufWe;

   logic [ADDR_W-1:0]   regOff;
   logic                busOwner;
   logic                regWrEn;
   logic [DATA_W-1:0]   wrData;

   // Register writes are only taken while we do not hold the bus and no transfer is running.
   assign regOff   = acc_addr_in - BASE;
   assign busOwner = (state_q inside {REQ, RD_A, RD_D, WR, NEXT}) && arb_res;
   assign regWrEn  = acc_write_in && !busOwner && !ctrl_q[7] && (regOff < ADDR_W'(6));

`ifdef CAL_ACC_INV_EN
   assign wrData = ctrl_q[0] ? ~buf_q[idx_q] : buf_q[idx_q];
`else
   assign wrData = buf_q[idx_q];
`endif

   // wrPhase_q remembers whether a lost grant happened during the write half, so re-grant resumes there.
   always_comb begin
      state_d   = state_q;
      ctrl_d    = ctrl_q;
      src_d     = src_q;
      dst_d     = dst_q;
      len_d     = len_q;
      idx_d     = idx_q;
      wrPhase_d = wrPhase_q;
      int_d     = int_q;
      bufWe     = 1'b0;

      if (regWrEn) begin
         case (regOff[2:0])
            3'd0: begin
               ctrl_d = acc_data_in;
               int_d  = 1'b0;
            end
            3'd1:    src_d[ADDR_W-1:DATA_W] = acc_data_in[HW-1:0];
            3'd2:    src_d[DATA_W-1:0]      = acc_data_in;
            3'd3:    dst_d[ADDR_W-1:DATA_W] = acc_data_in[HW-1:0];
            3'd4:    dst_d[DATA_W-1:0]      = acc_data_in;
            3'd5:    len_d                  = acc_data_in;
            default: ;
         endcase
      end

      case (state_q)
         IDLE: begin
            idx_d     = '0;
            wrPhase_d = 1'b0;
            if (ctrl_q[7]) begin
               state_d = (len_q != '0) ? REQ : DONE;
            end
         end
         REQ: begin
            if (arb_res) begin
               state_d = wrPhase_q ? WR : RD_A;
            end
         end
         RD_A: begin
            state_d = arb_res ? RD_D : REQ;
         end
         RD_D: begin
            if (!arb_res) begin
               state_d = REQ;
            end else begin
               bufWe = 1'b1;
               if (idx_q == LAST_IDX) begin
                  idx_d     = '0;
                  wrPhase_d = 1'b1;
                  state_d   = WR;
               end else begin
                  idx_d   = idx_q + IW'(1);
                  state_d = RD_A;
               end
            end
         end
         WR: begin
            if (!arb_res) begin
               state_d = REQ;
            end else if (idx_q == LAST_IDX) begin
               idx_d   = '0;
               state_d = NEXT;
            end else begin
               idx_d = idx_q + IW'(1);
            end
         end
         NEXT: begin
            src_d     = src_q + STEP;
            dst_d     = dst_q + STEP;
            len_d     = len_q - DATA_W'(1);
            wrPhase_d = 1'b0;
            if (len_q != DATA_W'(1)) begin
               state_d = arb_res ? RD_A : REQ;
            end else begin
               state_d = DONE;
            end
         end
         DONE: begin
            ctrl_d[7] = 1'b0;
            if (ctrl_q[6]) begin
               int_d = 1'b1;
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Bus strobes are gated by rst_n so a reset kills any access in the very cycle it is asserted.
   always_comb begin
      acc_req       = 1'b0;
      acc_write_out = 1'b0;
      acc_addr_out  = '0;
      acc_data_out  = '0;
      case (state_q)
         REQ, NEXT: acc_req = rst_n;
         RD_A, RD_D: begin
            acc_req      = rst_n;
            acc_addr_out = src_q + ADDR_W'(idx_q);
         end
         WR: begin
            acc_req       = rst_n;
            acc_addr_out  = dst_q + ADDR_W'(idx_q);
            acc_data_out  = wrData;
            acc_write_out = rst_n & arb_res;
         end
         default: ;
      endcase
   end

   assign acc_int = int_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         ctrl_q    <= '0;
         src_q     <= '0;
         dst_q     <= '0;
         len_q     <= '0;
         idx_q     <= '0;
         wrPhase_q <= 1'b0;
         int_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         ctrl_q    <= ctrl_d;
         src_q     <= src_d;
         dst_q     <= dst_d;
         len_q     <= len_d;
         idx_q     <= idx_d;
         wrPhase_q <= wrPhase_d;
         int_q     <= int_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < BURST; k++) begin
            buf_q[k] <= '0;
         end
      end else if (bufWe) begin
         buf_q[idx_q] <= acc_data_in;
      end
   end

endmodule
